pe_dot_ctrl: RTL
================

Name: pe_dot_ctrl

Overview:
Sequencer for one fixed-point MAC processing element (PE) with a local RAM.
- LOAD phase: streams vector B into the PE local RAM.
- CALC phase: streams vector A element by element, feeding the running sum back through the PE's C input, and returns the dot product A·B.
- Sits between the AXI-side data movers and a single PE instance; one dot product per start.

Parameters:
- L_RAM_SIZE, 6: PE local RAM address width; max vector length 2**L_RAM_SIZE.
- MAC_LAT, 4: cycles from PE sampling ain/bin/cin to a valid pe_dout.

Ports:
- aclk  in  1  clock; all state changes on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- start  in  1  pulse to begin a LOAD+CALC job; sampled only in IDLE.
- vec_len  in  L_RAM_SIZE+1  element count; latched on start.
- ld_data  in  32  B element, Q24.8.
- ld_valid  in  1  ld_data valid.
- ld_ready  out  1  controller accepts B element.
- a_data  in  32  A element, Q24.8.
- a_valid  in  1  a_data valid.
- a_ready  out  1  controller accepts A element.
- pe_ain  out  32  PE port A operand.
- pe_din  out  32  PE RAM write data.
- pe_cin  out  32  PE addend, running sum in Q24.8.
- pe_addr  out  L_RAM_SIZE  PE RAM address.
- pe_we  out  1  PE RAM write enable.
- pe_valid  out  1  PE operand-valid.
- pe_dout  in  32  PE result, Q24.8.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when result is valid.
- result  out  32  final dot product, Q24.8; held until next start.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; internal idx, wait counter and acc cleared. A job in flight is abandoned; no done pulse.
- States: IDLE, LOAD, RD, EXEC, FIN.
- IDLE:
  - On start=1: latch vec_len to len_q; clear acc and idx.
  - If len_q==0, go to FIN (result=0); else go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - ld_ready=1; pe_addr=idx; pe_din=ld_data; pe_we=ld_valid.
  - Each ld_valid&&ld_ready writes one word and increments idx.
  - On the write with idx==len_q-1: clear idx, go to RD.
  - ld_valid low inserts stall cycles with no write.
- RD:
  - pe_we=0; pe_addr=idx; a_ready=1.
  - On a_valid: latch a_data into ain_q, go to EXEC. The RAM read word is available from the next cycle.
- EXEC:
  - Lasts MAC_LAT+1 cycles.
  - Drive pe_ain=ain_q, pe_cin=acc, pe_addr=idx (held), pe_valid=1, pe_we=0.
  - All PE inputs are stable for the whole state.
  - On the last cycle: acc<=pe_dout. If idx==len_q-1, go to FIN; else idx++ and go to RD.
- FIN: result<=acc; done=1 for exactly one cycle; go to IDLE.
- Per-element latency: MAC_LAT+2 cycles with a_valid held high; LOAD takes len_q cycles with ld_valid held high.
- Arithmetic:
  - Controller does no arithmetic; overflow wraps inside the PE (Q24.8, 32-bit).
  - pe_cin carries the full 32-bit acc.
- Outputs not listed for a state are 0 (pe_ain, pe_din, pe_cin, pe_addr included).
- vec_len > 2**L_RAM_SIZE is clamped to 2**L_RAM_SIZE.

Optional Feature:
PE_DOT_CTRL_PERF_EN
- Defined: adds output cyc_cnt[31:0].
  - Cleared on start accept.
  - Increments every cycle while busy.
  - Frozen from FIN until the next start.
  - Reset value 0.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Basic job: MAC_LAT=4, vec_len=4, B=A={0x100,0x200,0x300,0x400}, valids always high → done exactly 4+4*6+1 cycles after start accept; result=0x1E00 (30.0).
- Zero-length job: start with vec_len=0 → FIN next cycle; done pulse; result=0; pe_we never asserted.
- Backpressure: ld_valid toggling 1,0,1,0 and a_valid low 3 cycles before each element → same result as the basic job; no extra RAM writes; pe_* inputs stable across each EXEC.
- Start while busy: pulse start again during EXEC → ignored; single done pulse; result unchanged vs the basic job.
- Reset mid-op: deassert then reassert aresetn during EXEC of element 2 → busy=0, done=0, result=0 immediately; a new job with vec_len=1, B={0x200}, A={0x300} returns 0x600.
- Perf (with PE_DOT_CTRL_PERF_EN): basic job → cyc_cnt=29 at done; value held after IDLE.

Source files
------------

// File: rtl/pe_dot_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_dot_ctrl_if
//  Description : Bus between the dot-product sequencer and one MAC PE with
//                a local RAM.
//                master (sequencer): drives pe_ain, pe_din, pe_cin, pe_addr,
//                                    pe_we, pe_valid; receives pe_dout
//                slave  (PE)       : the reverse
//  Revision    : 1.0 - initial release
// ============================================================================
interface pe_dot_ctrl_if #(
    parameter int L_RAM_SIZE = 6
);
    logic [31:0]           pe_ain;    // port A operand, Q24.8
    logic [31:0]           pe_din;    // local RAM write data
    logic [31:0]           pe_cin;    // addend (running sum), Q24.8
    logic [L_RAM_SIZE-1:0] pe_addr;   // local RAM address
    logic                  pe_we;     // local RAM write enable
    logic                  pe_valid;  // operands valid
    logic [31:0]           pe_dout;   // MAC result, Q24.8

    modport master (
        output pe_ain, pe_din, pe_cin, pe_addr, pe_we, pe_valid,
        input  pe_dout
    );

    modport slave (
        input  pe_ain, pe_din, pe_cin, pe_addr, pe_we, pe_valid,
        output pe_dout
    );
endinterface
`default_nettype wire

// File: rtl/pe_dot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pe_dot_ctrl
//  Description : Sequencer for one fixed-point MAC PE. LOAD streams vector B
//                into the PE RAM, CALC streams vector A one element at a
//                time and feeds the running sum back through pe_cin. One dot
//                product per start.
//  Ports       : aclk, aresetn (async, active low)
//                start, vec_len          - job request (sampled in IDLE)
//                ld_data/valid/ready     - B element stream
//                a_data/valid/ready      - A element stream
//                pe                      - PE bus (pe_dot_ctrl_if.master)
//                busy, done, result      - status and final sum (Q24.8)
//                cyc_cnt                 - busy-cycle counter, only when
//                                          PE_DOT_CTRL_PERF_EN is defined
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_dot_ctrl #(
    parameter int L_RAM_SIZE = 6,
    parameter int MAC_LAT    = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [L_RAM_SIZE:0]   vec_len,
    input  logic [31:0]           ld_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [31:0]           a_data,
    input  logic                  a_valid,
    output logic                  a_ready,
    pe_dot_ctrl_if.master         pe,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           result
`ifdef PE_DOT_CTRL_PERF_EN
    ,
    output logic [31:0]           cyc_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RD   = 3'd2,
        S_EXEC = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam int                  c_wait_w   = $clog2(MAC_LAT + 2);
    localparam logic [c_wait_w-1:0] c_wait_end = c_wait_w'(MAC_LAT);
    localparam logic [L_RAM_SIZE:0] c_max_len  = {1'b1, {L_RAM_SIZE{1'b0}}};

    state_t                r_state;
    logic [L_RAM_SIZE:0]   r_len;
    logic [L_RAM_SIZE-1:0] r_idx;
    logic [c_wait_w-1:0]   r_wait;
    logic [31:0]           r_acc;
    logic [31:0]           r_ain;
    logic [31:0]           r_result;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_ld_ready;
    logic                  r_a_ready;
    logic                  r_pe_valid;

    logic [L_RAM_SIZE:0]   w_len_clamp;
    logic                  w_last;
    logic                  w_ld_hs;
    logic                  w_a_hs;

    assign w_len_clamp = (vec_len > c_max_len) ? c_max_len : vec_len;
    // r_len is at least 1 whenever this is consulted (LOAD/EXEC)
    assign w_last      = ({1'b0, r_idx} == (r_len - 1'b1));
    assign w_ld_hs     = r_ld_ready & ld_valid;
    assign w_a_hs      = r_a_ready & a_valid;

    // Handshake/status flags are registered alongside each state transition
    // so they always equal "current state is X". r_idx is returned to zero
    // whenever the sequencer leaves the addressing states, which keeps
    // pe_addr at zero in IDLE/FIN without extra decode.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_wait     <= '0;
            r_acc      <= '0;
            r_ain      <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_ld_ready <= 1'b0;
            r_a_ready  <= 1'b0;
            r_pe_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len  <= w_len_clamp;
                        r_acc  <= '0;
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                        if (w_len_clamp == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state    <= S_LOAD;
                            r_ld_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_ld_hs) begin
                        if (w_last) begin
                            r_idx      <= '0;
                            r_ld_ready <= 1'b0;
                            r_a_ready  <= 1'b1;
                            r_state    <= S_RD;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_RD: begin
                    // RAM read of r_idx is issued here; word is at the PE
                    // from the first EXEC cycle onward.
                    if (w_a_hs) begin
                        r_ain      <= a_data;
                        r_a_ready  <= 1'b0;
                        r_pe_valid <= 1'b1;
                        r_wait     <= '0;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_wait == c_wait_end) begin
                        r_acc      <= pe.pe_dout;
                        r_pe_valid <= 1'b0;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_FIN;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_a_ready <= 1'b1;
                            r_state   <= S_RD;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_FIN: begin
                    // done rises together with the updated result
                    r_result <= r_acc;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_idx      <= '0;
                    r_busy     <= 1'b0;
                    r_ld_ready <= 1'b0;
                    r_a_ready  <= 1'b0;
                    r_pe_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready    = r_ld_ready;
    assign a_ready     = r_a_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign pe.pe_valid = r_pe_valid;
    assign pe.pe_addr  = r_idx;
    assign pe.pe_we    = w_ld_hs;
    assign pe.pe_din   = r_ld_ready ? ld_data : 32'd0;
    assign pe.pe_ain   = r_pe_valid ? r_ain   : 32'd0;
    assign pe.pe_cin   = r_pe_valid ? r_acc   : 32'd0;

`ifdef PE_DOT_CTRL_PERF_EN
    logic [31:0] r_cyc_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cyc_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_cyc_cnt <= '0;
        end else if (r_busy) begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
        end
    end

    assign cyc_cnt = r_cyc_cnt;
`endif

endmodule
`default_nettype wire
